// File: rtl/riscv_memory_responder_if.sv
// Memory bus between riscv_core (master) and its memory responder (slave).
// Every cycle is a transaction: no valid/ready, read data returns one edge later.
interface riscv_memory_responder_if;
  logic [31:0] imem_addr;          // fetch byte address
  logic [31:0] imem_data;          // fetched instruction
  logic [31:0] dmem_addr;          // data byte address
  logic [31:0] dmem_wdata;         // store data, lane-aligned
  logic [3:0]  dmem_write_enable;  // byte-lane strobes, 4'b0000 = load
  logic [31:0] dmem_rdata;         // load data

  modport master (
    output imem_addr,
    output dmem_addr,
    output dmem_wdata,
    output dmem_write_enable,
    input  imem_data,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_write_enable,
    output imem_data,
    output dmem_rdata
  );
endinterface

// File: rtl/riscv_memory_responder.sv
// Target end of riscv_core's memory bus: dual-port word RAM (fetch + data with
// byte strobes) and a small MMIO window holding a 64-bit cycle counter with a
// coherent hi shadow, a sticky-halt tohost register and a 16-bit LED register.
// RAM has no reset; only the read registers and MMIO state are reset.
module riscv_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  riscv_memory_responder_if.slave bus,
  output logic [31:0]             tohost_out,
  output logic                    halt_out,
  output logic [15:0]             led_out
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] imem_idx;
  logic [AW-1:0] dmem_idx;
  logic          mmio_sel;
  logic          mmio_hit;
  logic [1:0]    mmio_off;
  logic          is_load;
  logic [3:0]    ram_we;
  logic [31:0]   lane_mask;
  logic [31:0]   mmio_rdata;
  logic          tohost_wr;

  logic [31:0] imem_data_q;
  logic [31:0] dmem_data_q;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] tohost_q, tohost_d;
  logic [15:0] led_q, led_d;
  logic        halt_q, halt_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.imem_addr[31:AW+2], bus.imem_addr[1:0], bus.dmem_addr[1:0]};

  // Out-of-range addresses alias: only the low index bits are kept.
  assign imem_idx  = bus.imem_addr[AW+1:2];
  assign dmem_idx  = bus.dmem_addr[AW+1:2];
  assign mmio_sel  = bus.dmem_addr[31];
  assign mmio_hit  = mmio_sel && (bus.dmem_addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off  = bus.dmem_addr[3:2];
  assign is_load   = (bus.dmem_write_enable == 4'b0000);
  assign ram_we    = mmio_sel ? 4'b0000 : bus.dmem_write_enable;
  assign lane_mask = {{8{bus.dmem_write_enable[3]}}, {8{bus.dmem_write_enable[2]}},
                      {8{bus.dmem_write_enable[1]}}, {8{bus.dmem_write_enable[0]}}};
  assign tohost_wr = mmio_hit && (mmio_off == 2'd2) && !is_load;

  // Counter freezes once halted; wraps naturally at 2^64.
  assign cycle_d = halt_q ? cycle_q : cycle_q + 64'd1;

  // MMIO read mux; misses inside the window read as zero.
  always_comb begin
    mmio_rdata = '0;
    if (mmio_hit) begin
      case (mmio_off)
        2'd0:    mmio_rdata = cycle_q[31:0];
        2'd1:    mmio_rdata = hi_q;
        2'd2:    mmio_rdata = tohost_q;
        default: mmio_rdata = {16'h0000, led_q};
      endcase
    end
  end

  // MMIO next-state: shadow capture on CYCLE_LO load, strobed RW writes, sticky halt.
  always_comb begin
    hi_d     = hi_q;
    tohost_d = tohost_q;
    led_d    = led_q;
    if (mmio_hit) begin
      if (is_load) begin
        if (mmio_off == 2'd0) hi_d = cycle_q[63:32];
      end else if (mmio_off == 2'd2) begin
        tohost_d = (tohost_q & ~lane_mask) | (bus.dmem_wdata & lane_mask);
      end else if (mmio_off == 2'd3) begin
        led_d = (led_q & ~lane_mask[15:0]) | (bus.dmem_wdata[15:0] & lane_mask[15:0]);
      end
    end
    halt_d = halt_q | (tohost_wr && (tohost_d != '0));
  end

  // RAM write port; reads below sample pre-edge contents, giving read-first collisions.
  always_ff @(posedge clk_in) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[dmem_idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
    end
  end

  // Registered read data and MMIO state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      imem_data_q <= NOP;
      dmem_data_q <= '0;
      cycle_q     <= '0;
      hi_q        <= '0;
      tohost_q    <= '0;
      led_q       <= '0;
      halt_q      <= 1'b0;
    end else begin
      imem_data_q <= mem[imem_idx];
      dmem_data_q <= mmio_sel ? mmio_rdata : mem[dmem_idx];
      cycle_q     <= cycle_d;
      hi_q        <= hi_d;
      tohost_q    <= tohost_d;
      led_q       <= led_d;
      halt_q      <= halt_d;
    end
  end

  assign bus.imem_data  = imem_data_q;
  assign bus.dmem_rdata = dmem_data_q;
  assign tohost_out     = tohost_q;
  assign halt_out       = halt_q;
  assign led_out        = led_q;

endmodule

// File: tb/tb_riscv_memory_responder.sv
// Bench for riscv_memory_responder: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_riscv_memory_responder;

  localparam int unsigned DEPTH     = 64;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tohost;
  logic        halt;
  logic [15:0] led;

  riscv_memory_responder_if bus_if ();

  riscv_memory_responder #(
    .DEPTH_WORDS(DEPTH),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus_if),
    .tohost_out(tohost),
    .halt_out  (halt),
    .led_out   (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];
  logic [63:0] m_cnt = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_tohost = '0;
  logic [31:0] m_led = '0;
  logic        m_halt = 1'b0;
  logic [31:0] e_imem = NOP;
  logic [31:0] e_dmem = '0;
  bit          e_i_known = 1'b1;
  bit          e_d_known = 1'b1;
  bit          force_pend = 1'b0;
  logic [63:0] force_val = '0;

  logic [31:0] a_i, a_d, wd, mask;
  logic [3:0]  st;
  logic [63:0] nxt_cnt;
  int unsigned wi, wdi, reg_no;

  // Model: every edge is one transaction computed from pre-edge state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = '0; m_hi = '0; m_tohost = '0; m_led = '0; m_halt = 1'b0;
      e_imem = NOP; e_i_known = 1'b1; e_dmem = '0; e_d_known = 1'b1;
    end else begin
      a_i = bus_if.imem_addr;
      a_d = bus_if.dmem_addr;
      wd  = bus_if.dmem_wdata;
      st  = bus_if.dmem_write_enable;
      mask = '0;
      for (int b = 0; b < 4; b++) if (st[b]) mask = mask | (32'hFF << (8 * b));
      wi  = (a_i / 4) % DEPTH;
      wdi = (a_d / 4) % DEPTH;
      e_imem = m_mem[wi];
      e_i_known = m_valid[wi];
      nxt_cnt = m_halt ? m_cnt : m_cnt + 64'd1;
      if (force_pend) begin
        nxt_cnt = force_val;
        force_pend = 1'b0;
      end
      if (a_d >= 32'h8000_0000) begin
        e_d_known = 1'b1;
        e_dmem = '0;
        if ((a_d >> 4) == (MMIO_BASE >> 4)) begin
          reg_no = (a_d % 16) / 4;
          case (reg_no)
            0:       e_dmem = m_cnt[31:0];
            1:       e_dmem = m_hi;
            2:       e_dmem = m_tohost;
            default: e_dmem = m_led;
          endcase
          if (st == 4'b0000) begin
            if (reg_no == 0) m_hi = m_cnt[63:32];
          end else if (reg_no == 2) begin
            m_tohost = (m_tohost & ~mask) | (wd & mask);
            if (m_tohost != 0) m_halt = 1'b1;
          end else if (reg_no == 3) begin
            m_led = ((m_led & ~mask) | (wd & mask)) & 32'h0000_FFFF;
          end
        end
      end else begin
        e_dmem = m_mem[wdi];
        e_d_known = m_valid[wdi];
        if (st != 4'b0000) begin
          m_mem[wdi] = (m_mem[wdi] & ~mask) | (wd & mask);
          if (st == 4'hF) m_valid[wdi] = 1'b1;
        end
      end
      m_cnt = nxt_cnt;
    end
  end

  // Compare DUT against model away from the active edge.
  always @(negedge clk) begin
    if (e_i_known) check("imem_data", bus_if.imem_data, e_imem);
    if (e_d_known) check("dmem_data", bus_if.dmem_rdata, e_dmem);
    check("tohost", tohost, m_tohost);
    check("halt", halt, m_halt);
    check("led", led, m_led[15:0]);
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wdat,
                      input logic [3:0] we);
    bus_if.imem_addr         = ia;
    bus_if.dmem_addr         = da;
    bus_if.dmem_wdata        = wdat;
    bus_if.dmem_write_enable = we;
    @(negedge clk);
  endtask

  task automatic force_counter(input logic [63:0] v);
    force_val  = v;
    force_pend = 1'b1;
    force dut.cycle_d = v;
    @(posedge clk);
    #1;
    release dut.cycle_d;
    @(negedge clk);
  endtask

  logic [31:0] r_ia, r_da, r_wd;
  logic [3:0]  r_we;
  int unsigned r_off;

  initial begin
    bus_if.imem_addr = '0;
    bus_if.dmem_addr = '0;
    bus_if.dmem_wdata = '0;
    bus_if.dmem_write_enable = '0;
    repeat (3) @(negedge clk);
    check("rst_imem_nop", bus_if.imem_data, NOP);
    check("rst_dmem_zero", bus_if.dmem_rdata, 32'h0);
    check("rst_halt", halt, 1'b0);
    check("rst_tohost", tohost, 32'h0);
    check("rst_led", led, 16'h0);
    rst_n = 1'b1;
    xact(32'h0, MMIO_BASE, 32'h0, 4'b0000);
    check("cycle_lo_after_reset", bus_if.dmem_rdata, 32'h0);

    // Fill the working region with known words.
    for (int w = 0; w <= 16; w++) xact(32'h0, 32'(w * 4), $urandom(), 4'hF);

    // Byte-lane stores.
    xact(32'h0, 32'h10, 32'hDEAD_BEEF, 4'hF);
    xact(32'h0, 32'h10, 32'h0000_AA00, 4'b0010);
    xact(32'h0, 32'h10, 32'h0, 4'b0000);
    check("byte_store_lane1", bus_if.dmem_rdata, 32'hDEAD_AAEF);
    xact(32'h0, 32'h10, 32'h1234_0000, 4'b1100);
    xact(32'h0, 32'h10, 32'h0, 4'b0000);
    check("byte_store_hi_half", bus_if.dmem_rdata, 32'h1234_AAEF);

    // Read-first collisions on both ports.
    xact(32'h0, 32'h20, 32'h0, 4'hF);
    xact(32'h20, 32'h20, 32'h1111_1111, 4'hF);
    check("collide_imem_old", bus_if.imem_data, 32'h0);
    check("collide_dmem_old", bus_if.dmem_rdata, 32'h0);
    xact(32'h20, 32'h20, 32'h0, 4'b0000);
    check("collide_imem_new", bus_if.imem_data, 32'h1111_1111);
    check("collide_dmem_new", bus_if.dmem_rdata, 32'h1111_1111);

    // Fetch with aliasing and addr[31] set on the fetch port.
    xact(32'h0, 32'h4, 32'h0001_3237, 4'hF);
    xact(32'h4 + DEPTH * 4, 32'h0, 32'h0, 4'b0000);
    check("fetch_alias", bus_if.imem_data, 32'h0001_3237);
    xact(32'h8000_0004, 32'h0, 32'h0, 4'b0000);
    check("fetch_bit31_ram", bus_if.imem_data, 32'h0001_3237);

    // LED register: only 16 bits kept.
    xact(32'h0, MMIO_BASE + 32'hC, 32'hABCD_1234, 4'hF);
    xact(32'h0, MMIO_BASE + 32'hC, 32'h0, 4'b0000);
    check("led_read", bus_if.dmem_rdata, 32'h0000_1234);
    check("led_out", led, 16'h1234);

    // Mid-run reset leaves RAM intact.
    xact(32'h0, 32'h40, 32'hCAFE_F00D, 4'hF);
    xact(32'h40, 32'h40, 32'h0, 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_imem_nop", bus_if.imem_data, NOP);
    check("midrst_dmem_zero", bus_if.dmem_rdata, 32'h0);
    check("midrst_led", led, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(32'h40, 32'h40, 32'h0, 4'b0000);
    check("ram_kept_dmem", bus_if.dmem_rdata, 32'hCAFE_F00D);
    check("ram_kept_imem", bus_if.imem_data, 32'hCAFE_F00D);

    // Randomized traffic over the working region, aliases and the MMIO window.
    for (int k = 0; k < 400; k++) begin
      r_ia = ($urandom_range(0, 15) << 2) | ($urandom() & 32'h3) |
             ($urandom_range(0, 3) * DEPTH * 4) | ($urandom_range(0, 1) << 31);
      r_wd = $urandom();
      if ($urandom_range(0, 9) < 7) begin
        r_da = ($urandom_range(0, 16) << 2) | ($urandom() & 32'h3) |
               ($urandom_range(0, 3) * DEPTH * 4);
        r_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom());
      end else begin
        r_off = $urandom_range(0, 3);
        r_da = MMIO_BASE | 32'(r_off << 2) | (($urandom_range(0, 4) == 0) ? 32'h100 : 32'h0);
        r_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom());
        if (r_off == 2 && r_da[8] == 1'b0) r_wd = 32'h0;
      end
      xact(r_ia, r_da, r_wd, r_we);
    end

    // Counter: hi shadow coherency across a 32-bit carry.
    xact(32'h0, 32'h0, 32'h0, 4'b0000);
    force_counter(64'h0000_0000_FFFF_FFFF);
    xact(32'h0, 32'h4, 32'h0, 4'b0000);
    xact(32'h0, MMIO_BASE, 32'h0, 4'b0000);
    check("cycle_lo_carry", bus_if.dmem_rdata, 32'h0);
    xact(32'h0, MMIO_BASE + 32'h4, 32'h0, 4'b0000);
    check("cycle_hi_shadow", bus_if.dmem_rdata, 32'h1);
    // Counter wrap at 2^64.
    force_counter(64'hFFFF_FFFF_FFFF_FFFF);
    xact(32'h0, MMIO_BASE, 32'h0, 4'b0000);
    check("cycle_lo_max", bus_if.dmem_rdata, 32'hFFFF_FFFF);
    xact(32'h0, MMIO_BASE, 32'h0, 4'b0000);
    check("cycle_lo_wrapped", bus_if.dmem_rdata, 32'h0);
    xact(32'h0, MMIO_BASE + 32'h4, 32'h0, 4'b0000);
    check("cycle_hi_wrapped", bus_if.dmem_rdata, 32'h0);

    // Halt via byte store to tohost, then sticky across a zero write.
    xact(32'h0, MMIO_BASE + 32'h8, 32'h0000_0001, 4'b0001);
    check("tohost_set", tohost, 32'h1);
    check("halt_set", halt, 1'b1);
    xact(32'h0, MMIO_BASE, 32'h0, 4'b0000);
    xact(32'h0, MMIO_BASE, 32'h0, 4'b0000);
    xact(32'h0, MMIO_BASE + 32'h8, 32'h0, 4'hF);
    check("tohost_cleared", tohost, 32'h0);
    check("halt_sticky", halt, 1'b1);
    for (int k = 0; k < 40; k++) begin
      r_off = $urandom_range(0, 3);
      xact(32'($urandom_range(0, 15) << 2), MMIO_BASE | 32'(r_off << 2), $urandom(),
           ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
